// File: rtl/wb_stage.sv
// Write-back stage: holds one MEM/WB entry, commits it into the architectural
// register file, and serves decode read ports with write-through bypass.
module wb_stage #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [4:0]       in_rd,
   input  logic             in_reg_wen,
   input  logic             in_load_valid,
   input  logic [XLEN-1:0]  in_alu_data,
   input  logic [XLEN-1:0]  in_mem_data,
   input  logic             hold,
   input  logic [4:0]       rs1_addr,
   input  logic [4:0]       rs2_addr,
   output logic [XLEN-1:0]  rs1_data,
   output logic [XLEN-1:0]  rs2_data,
   output logic             fwd_valid,
   output logic [4:0]       fwd_rd,
   output logic [XLEN-1:0]  fwd_data,
   output logic             retire_valid,
   output logic [XLEN-1:0]  retire_pc,
   output logic [CNT_W-1:0] retire_count
);

   // state | meaning
   // EMPTY | no entry held; always ready
   // FULL  | entry held; commits on any cycle without hold
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t            state;
   logic [XLEN-1:0]   pc_q;
   logic [4:0]        rd_q;
   logic              reg_wen_q;
   logic [XLEN-1:0]   wb_data_q;
   logic [XLEN-1:0]   regs [NREG];

   logic valid_q;
   logic commit;
   logic commit_wr;
   logic accept;

   assign valid_q   = (state == FULL);
   assign in_ready  = ~valid_q | ~hold;
   assign commit    = valid_q & ~hold;
   assign commit_wr = commit & reg_wen_q & (rd_q != 5'd0);
   assign accept    = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= EMPTY;
         pc_q         <= '0;
         rd_q         <= '0;
         reg_wen_q    <= 1'b0;
         wb_data_q    <= '0;
         retire_count <= '0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         if (commit) begin
            retire_count <= retire_count + CNT_W'(1);
            if (commit_wr) regs[rd_q] <= wb_data_q;
         end
         // Load data is selected here so MEM only needs to hold it for the accept cycle.
         if (accept) begin
            state     <= FULL;
            pc_q      <= in_pc;
            rd_q      <= in_rd;
            reg_wen_q <= in_reg_wen;
            wb_data_q <= in_load_valid ? in_mem_data : in_alu_data;
         end else if (commit) begin
            state <= EMPTY;
         end
      end
   end

   function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
      if (addr == 5'd0)                  return '0;
      else if (commit_wr && addr == rd_q) return wb_data_q;
      else                               return regs[addr];
   endfunction

   always_comb begin
      rs1_data = read_port(rs1_addr);
      rs2_data = read_port(rs2_addr);
   end

   assign retire_valid = commit;
   assign retire_pc    = pc_q;
   assign fwd_valid    = valid_q & reg_wen_q & (rd_q != 5'd0);
   assign fwd_rd       = rd_q;
   assign fwd_data     = wb_data_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage directly downstream of the memory-access stage in the NPC pipeline.
- Holds one MEM/WB pipeline entry. Selects the result to write: load data for loads, ALU result otherwise.
- Commits the result into the 32-entry architectural register file and exposes a retire event, a retire counter and forwarding info.
- Provides the register-file read ports used by the decode stage, with write-through bypass.

Parameters:
XLEN, 32, datapath width
NREG, 32, number of architectural registers (x0 hardwired to zero)
CNT_W, 64, retire counter width

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous, active-low reset (rst==0 resets)
in_valid  input  1  MEM stage presents an entry
in_ready  output  1  wb_stage can accept an entry this cycle
in_pc  input  XLEN  pc of the entry
in_rd  input  5  destination register
in_reg_wen  input  1  entry writes rd (0 for stores/branches)
in_load_valid  input  1  entry is a load; select in_mem_data
in_alu_data  input  XLEN  ALU/address result from EX
in_mem_data  input  XLEN  extended load data from MEM
hold  input  1  downstream stall (difftest/debug); blocks commit
rs1_addr  input  5  read port 1 address
rs2_addr  input  5  read port 2 address
rs1_data  output  XLEN  read port 1 data
rs2_data  output  XLEN  read port 2 data
fwd_valid  output  1  held entry will write a nonzero rd
fwd_rd  output  5  rd of held entry
fwd_data  output  XLEN  write-back value of held entry
retire_valid  output  1  one-cycle pulse when an entry commits
retire_pc  output  XLEN  pc of committing entry
retire_count  output  CNT_W  number of committed entries

Behaviour:
- Reset (rst low, async): valid_q=0; all 32 registers=0; retire_count=0. Outputs: retire_valid=0, fwd_valid=0, retire_pc=0, fwd_rd=0, fwd_data=0.
- States: EMPTY (valid_q=0) and FULL (valid_q=1).
  - EMPTY: in_ready=1. in_valid -> latch entry, go to FULL.
  - FULL, hold=0: commit this cycle. in_ready=1. New in_valid latches the next entry (stay FULL), else go to EMPTY.
  - FULL, hold=1: no commit, in_ready=0, entry unchanged.
- Latched wb_data = in_load_valid ? in_mem_data : in_alu_data. Captured at accept time, so MEM data need only be stable during the accept cycle.
- Commit happens on the posedge ending a FULL, hold=0 cycle:
  - Register write occurs only if reg_wen_q && rd_q!=0; x0 is never written.
  - retire_count increments by 1 and wraps modulo 2^CNT_W.
- retire_valid, retire_pc: combinational. retire_valid = valid_q & ~hold; retire_pc = pc_q.
- Read ports are combinational.
  - Address 0 -> 0.
  - Address equal to a committing rd this cycle (valid_q & ~hold & reg_wen_q & rd_q!=0) -> wb_data_q (write-through bypass).
  - Otherwise the register array value.
- fwd_valid = valid_q & reg_wen_q & (rd_q!=0), independent of hold. fwd_rd = rd_q; fwd_data = wb_data_q.
- Simultaneous accept and commit: the old entry writes and the new entry latches on the same edge. No bubble; full throughput of 1 entry per cycle.
- Reset asserted mid-operation: the held entry is discarded without commit, registers clear, the counter clears.
- No combinational path from in_* to in_ready; in_ready depends only on valid_q and hold.

Test Plan:
- Reset, then read rs1_addr=5 -> rs1_data=0. retire_count=0, in_ready=1, retire_valid=0.
- ALU write: in_valid, rd=3, reg_wen=1, load_valid=0, alu=0x1234, pc=0x80000000.
  - Next cycle: retire_valid=1, retire_pc=0x80000000, fwd_valid=1, fwd_data=0x1234, rs1_addr=3 -> 0x1234 (bypass).
  - After the commit edge: reads 0x1234 from the array; retire_count=1.
- Load select: rd=4, load_valid=1, mem=0xFFFFFF80, alu=0x80001000 -> x4=0xFFFFFF80 after commit.
- x0 protection: rd=0, reg_wen=1, alu=0xDEAD -> x0 reads 0, fwd_valid=0, retire_count still increments.
- Hold: entry rd=7 alu=0x55 with hold=1 for 3 cycles.
  - During hold: in_ready=0, retire_valid=0, x7 unchanged, fwd_valid=1.
  - After release: one retire pulse, x7=0x55.
- Back-to-back: 4 consecutive entries writing x1..x4 = 1..4 with hold=0 -> four consecutive retire pulses, retire_count=4. Async reset mid-stream (while FULL) -> valid_q=0, all registers 0, count=0.
